// File: rtl/nv_reset_pkg.sv
// Shared definitions for the reset sequencer: default parameters, state encoding
// and the counter sizing helper.
package nv_reset_pkg;

  localparam int unsigned NCH_DEF        = 4;
  localparam int unsigned SYNC_DEPTH_DEF = 2;
  localparam int unsigned STRETCH_DEF    = 16;
  localparam int unsigned GAP_DEF        = 8;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } seq_state_e;

  // One spare bit above the largest terminal count keeps the counter from wrapping.
  function automatic int unsigned cnt_width(int unsigned stretch, int unsigned gap);
    return $clog2((stretch > gap) ? stretch : gap) + 1;
  endfunction

endpackage

// File: rtl/sync_reset_seq_sync.sv
// Level synchroniser for the asynchronous software reset request; kept as its own
// cell so the whole flop chain can be treated as one CDC crossing.
module sync_reset_seq_sync
  import nv_reset_pkg::*;
#(
  parameter int unsigned SYNC_DEPTH = SYNC_DEPTH_DEF
) (
  input  logic clk,
  input  logic inreset_,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!inreset_) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/sync_reset_seq.sv
// Reset sequencer: holds all channels in reset for STRETCH cycles, then releases
// them one by one in ascending order, GAP cycles apart, and flags completion.
module sync_reset_seq
  import nv_reset_pkg::*;
#(
  parameter int unsigned NCH        = NCH_DEF,
  parameter int unsigned SYNC_DEPTH = SYNC_DEPTH_DEF,
  parameter int unsigned STRETCH    = STRETCH_DEF,
  parameter int unsigned GAP        = GAP_DEF
) (
  input  logic           clk,
  input  logic           inreset_,
  input  logic           direct_reset_,
  input  logic           test_mode,
  input  logic           sw_rst_req,
  output logic [NCH-1:0] outreset_,
  output logic           rst_done
);

  localparam int unsigned CNT_W = cnt_width(STRETCH, GAP);
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NCH - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [NCH-1:0]   chan_q;
  logic             done_q;
  logic             edge_q;
  logic             sync_lvl;
  logic             sw_evt;

  sync_reset_seq_sync #(
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_sync (
    .clk      (clk),
    .inreset_ (inreset_),
    .async_i  (sw_rst_req),
    .sync_o   (sync_lvl)
  );

  // Only the rising edge of the synchronised level restarts the sequence.
  assign sw_evt = sync_lvl & ~edge_q;

  always_ff @(posedge clk) begin
    if (!inreset_) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      chan_q  <= '0;
      done_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      edge_q <= sync_lvl;
      if (sw_evt) begin
        state_q <= ASSERT;
        cnt_q   <= '0;
        idx_q   <= '0;
        chan_q  <= '0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          ASSERT: begin
            if (cnt_q == STRETCH_LAST) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              chan_q  <= NCH'(1);
              state_q <= (NCH == 1) ? DONE : RELEASE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          RELEASE: begin
            // Thermometer shift keeps release order strictly ascending.
            if (cnt_q == GAP_LAST) begin
              cnt_q  <= '0;
              idx_q  <= idx_q + IDX_W'(1);
              chan_q <= NCH'({chan_q, 1'b1});
              if (idx_q + IDX_W'(1) == IDX_LAST) begin
                state_q <= DONE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DONE: begin
            done_q <= 1'b1;
          end
          default: begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            chan_q  <= '0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Test-mode bypass is the only combinational path to the outputs.
  assign outreset_ = test_mode ? {NCH{direct_reset_}} : chan_q;
  assign rst_done  = test_mode | done_q;

endmodule

// File: doc/sync_reset_seq.md
SYNC_RESET_SEQ -- requirements
Module: sync_reset_seq

Interface
REQ-001 SHALL have parameter NCH, default 4, number of reset output channels (>=1).
REQ-002 SHALL have parameter SYNC_DEPTH, default 2, flop stages on the sw_rst_req synchroniser (>=2).
REQ-003 SHALL have parameter STRETCH, default 16, minimum all-channel assert length in cycles (>=1).
REQ-004 SHALL have parameter GAP, default 8, cycles between successive channel releases (>=1).
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port inreset_, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port direct_reset_, input, 1, test-mode reset source.
REQ-008 SHALL have port test_mode, input, 1, selects direct_reset_ onto all outputs.
REQ-009 SHALL have port sw_rst_req, input, 1, asynchronous level software reset request.
REQ-010 SHALL have port outreset_, output, NCH, per-channel active-low resets.
REQ-011 SHALL have port rst_done, output, 1, high once all channels are released.

Function
REQ-012 SHALL implement an FSM with states ASSERT, RELEASE and DONE, plus a cycle counter and a channel index.
REQ-013 In ASSERT, all outreset_ bits SHALL be low; the counter counts STRETCH cycles, then the FSM enters RELEASE with index 0.
REQ-014 In RELEASE, outreset_[k] SHALL rise at index k, and the index SHALL advance every GAP cycles; released channels SHALL stay high.
REQ-015 outreset_[k] SHALL first read high after the (STRETCH + k*GAP)-th consecutive rising edge with inreset_=1.
REQ-016 rst_done SHALL rise one cycle after outreset_[NCH-1] rises (DONE state), and SHALL be low in every other state.
REQ-017 sw_rst_req SHALL pass through SYNC_DEPTH flops, followed by a rising-edge detector; a held level SHALL produce one event.
REQ-018 A sync event in any state SHALL force ASSERT with the counter cleared; all outreset_ low and rst_done low on the next cycle.
REQ-019 A sync event during ASSERT SHALL restart the STRETCH count, so a back-to-back request extends the assertion.
REQ-020 With test_mode=1, outreset_ SHALL equal {NCH{direct_reset_}} combinationally, and rst_done SHALL be forced to 1; the FSM continues unaffected.
REQ-021 The transition from test_mode=1 to 0 SHALL expose the registered FSM outputs with no extra sequencing.
REQ-022 outreset_ release order SHALL be strictly ascending; no channel SHALL release before all lower channels.
REQ-023 Counter width SHALL be clog2(max(STRETCH,GAP))+1, and the counter SHALL never wrap within a state.

Reset
REQ-024 On a rising edge with inreset_=0, the block SHALL set: FSM to ASSERT, counter 0, index 0, synchroniser flops 0, edge-detect flop 0.
REQ-025 During reset, the registered outreset_ SHALL be all 0 and rst_done 0, one cycle after the reset edge.
REQ-026 inreset_ low mid-RELEASE or in DONE SHALL drop all channels at the next edge; sequencing SHALL restart from REQ-015 after inreset_ returns high.
REQ-027 inreset_ low SHALL take priority over a simultaneous sw_rst_req event.

Structure
REQ-028 State encoding and default parameter values SHALL live in the shared package nv_reset_pkg.
REQ-029 The sw_rst_req flop chain SHALL be sub-module sync_reset_seq_sync (parameter SYNC_DEPTH), so the CDC tool can waive it as one cell.
REQ-030 All outputs SHALL be driven by flops, except for the test_mode output mux.

Verification
REQ-031 Defaults; inreset_ low 5 cycles then high -> outreset_ steps 0000, 0001, 0011, 0111, 1111 at edges 16, 24, 32 and 40; rst_done=1 after edge 41.
REQ-032 DONE reached; sw_rst_req held high 100 cycles -> one event 3 cycles later (2-stage sync plus edge detect); all outreset_=0, then the REQ-031 sequence, and no second event.
REQ-033 sw_rst_req pulses again at stretch count 10 -> release of channel 0 is delayed to 16 cycles after the second event.
REQ-034 inreset_ dropped at edge 28 (outreset_=0011) -> 0000 at the next edge, and a full re-sequence follows.
REQ-035 test_mode=1 with direct_reset_ toggling during ASSERT -> outreset_=1111 or 0000 tracking it with zero latency, rst_done=1; after test_mode=0, the FSM state is visible.
REQ-036 NCH=1, STRETCH=1, GAP=1 -> outreset_ high after the first edge with inreset_=1, and rst_done high the cycle after.
